// File: rtl/load_store_unit_pkg.sv
// Shared encodings, request payload and access-sizing helpers for the load/store unit.
package load_store_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] LOAD_BYTE              = 3'b000;
  localparam logic [2:0] LOAD_HALFWORD          = 3'b001;
  localparam logic [2:0] LOAD_WORD              = 3'b010;
  localparam logic [2:0] LOAD_UNSIGNED_BYTE     = 3'b100;
  localparam logic [2:0] LOAD_UNSIGNED_HALFWORD = 3'b101;

  localparam logic [2:0] STORE_BYTE     = 3'b000;
  localparam logic [2:0] STORE_HALFWORD = 3'b001;
  localparam logic [2:0] STORE_WORD     = 3'b010;

  localparam logic [1:0] LSU_CAUSE_NONE         = 2'b00;
  localparam logic [1:0] LSU_CAUSE_MISALIGNED   = 2'b01;
  localparam logic [1:0] LSU_CAUSE_ACCESS_FAULT = 2'b10;
  localparam logic [1:0] LSU_CAUSE_ILLEGAL_SIZE = 2'b11;

  localparam logic [1:0] LSU_IDLE   = 2'd0;
  localparam logic [1:0] LSU_ACCESS = 2'd1;
  localparam logic [1:0] LSU_RESP   = 2'd2;

  typedef struct packed {
    logic            is_store;
    logic [2:0]      funct3;
    logic [XLEN-1:0] store_data;
  } lsu_req_t;

  // Loads allow the signed/unsigned byte and halfword forms plus word; stores only SB/SH/SW.
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
    if (is_store) return (funct3 == STORE_BYTE) || (funct3 == STORE_HALFWORD) ||
                         (funct3 == STORE_WORD);
    return (funct3 == LOAD_BYTE) || (funct3 == LOAD_HALFWORD) || (funct3 == LOAD_WORD) ||
           (funct3 == LOAD_UNSIGNED_BYTE) || (funct3 == LOAD_UNSIGNED_HALFWORD);
  endfunction

  // Number of memory sub-accesses: 1 when aligned, otherwise one per byte.
  function automatic logic [2:0] access_count(input logic [2:0] funct3, input logic [1:0] lsb);
    case (funct3[1:0])
      2'b01:   return lsb[0] ? 3'd2 : 3'd1;
      2'b10:   return (lsb != 2'b00) ? 3'd4 : 3'd1;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align_extend.sv
// Extends a byte-assembled load result; single-access results arrive already extended by memory.
module lsu_align_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [2:0]      count_i,
  input  logic [XLEN-1:0] value_i,
  output logic [XLEN-1:0] ext_data_c_o
);

  always_comb begin
    ext_data_c_o = value_i;
    if (count_i != 3'd1) begin
      case (funct3_i)
        LOAD_HALFWORD:          ext_data_c_o = {{16{value_i[15]}}, value_i[15:0]};
        LOAD_UNSIGNED_HALFWORD: ext_data_c_o = {16'b0, value_i[15:0]};
        default:                ext_data_c_o = value_i;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer: one request at a time, misaligned accesses split into byte accesses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter bit          SPLIT_MISALIGNED = 1'b1,
  parameter int unsigned ADDR_WIDTH       = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [XLEN-1:0]       req_store_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [XLEN-1:0]       resp_data,
  output logic                  resp_fault,
  output logic [1:0]            resp_cause,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic [XLEN-1:0]       mem_read_data,
  input  logic                  mem_illegal_read_address,
  input  logic                  mem_illegal_write_address,
  output logic [2:0]            mem_size_and_sign,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [XLEN-1:0]       mem_write_data,
  output logic                  mem_write_enable
);

  logic [1:0]            state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  lsu_req_t              req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            n_q, n_d;
  logic [1:0]            k_q, k_d;
  logic [XLEN-1:0]       asm_q, asm_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_fault_q, resp_fault_d;
  logic [1:0]            resp_cause_q, resp_cause_d;
  logic [XLEN-1:0]       resp_data_q, resp_data_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [2:0]            size_q, size_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic                  we_q, we_d;

  logic [1:0]            k_next_c;
  logic [2:0]            req_n_c;
  logic                  illegal_c;
  logic [XLEN-1:0]       asm_next_c;
  logic [XLEN-1:0]       ext_c;

  lsu_align_extend u_align_extend (
    .funct3_i     (req_q.funct3),
    .count_i      (n_q),
    .value_i      (asm_next_c),
    .ext_data_c_o (ext_c)
  );

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    req_d        = req_q;
    addr_d       = addr_q;
    n_d          = n_q;
    k_d          = k_q;
    asm_d        = asm_q;
    resp_valid_d = resp_valid_q;
    resp_fault_d = resp_fault_q;
    resp_cause_d = resp_cause_q;
    resp_data_d  = resp_data_q;
    raddr_d      = raddr_q;
    waddr_d      = waddr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    we_d         = we_q;

    k_next_c  = k_q + 2'd1;
    req_n_c   = access_count(req_funct3, req_address[1:0]);
    illegal_c = req_q.is_store ? mem_illegal_write_address : mem_illegal_read_address;
    // Current read data merged into the assembly buffer as of this cycle.
    asm_next_c = asm_q;
    if (n_q == 3'd1) asm_next_c = mem_read_data;
    else             asm_next_c[{k_q, 3'b000} +: 8] = mem_read_data[7:0];

    case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          req_d       = '{is_store: req_is_store, funct3: req_funct3, store_data: req_store_data};
          addr_d      = req_address;
          n_d         = req_n_c;
          k_d         = 2'd0;
          asm_d       = '0;
          req_ready_d = 1'b0;
          resp_data_d = '0;
          if (!funct3_legal(req_is_store, req_funct3)) begin
            state_d      = LSU_RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_cause_d = LSU_CAUSE_ILLEGAL_SIZE;
          end else if ((req_n_c != 3'd1) && !SPLIT_MISALIGNED) begin
            state_d      = LSU_RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_cause_d = LSU_CAUSE_MISALIGNED;
          end else begin
            state_d = LSU_ACCESS;
            raddr_d = req_address;
            waddr_d = req_address;
            we_d    = req_is_store;
            if (req_n_c == 3'd1) begin
              size_d  = req_funct3;
              wdata_d = req_store_data;
            end else begin
              size_d  = req_is_store ? STORE_BYTE : LOAD_UNSIGNED_BYTE;
              wdata_d = {24'b0, req_store_data[7:0]};
            end
          end
        end
      end

      LSU_ACCESS: begin
        asm_d = asm_next_c;
        if (illegal_c) begin
          state_d      = LSU_RESP;
          we_d         = 1'b0;
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b1;
          resp_cause_d = LSU_CAUSE_ACCESS_FAULT;
          resp_data_d  = '0;
        end else if (3'(k_q) == n_q - 3'd1) begin
          state_d      = LSU_RESP;
          we_d         = 1'b0;
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b0;
          resp_cause_d = LSU_CAUSE_NONE;
          resp_data_d  = req_q.is_store ? '0 : ext_c;
        end else begin
          k_d     = k_next_c;
          raddr_d = addr_q + ADDR_WIDTH'(k_next_c);
          waddr_d = addr_q + ADDR_WIDTH'(k_next_c);
          wdata_d = {24'b0, req_q.store_data[{k_next_c, 3'b000} +: 8]};
        end
      end

      LSU_RESP: begin
        if (resp_ready) begin
          state_d      = LSU_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = LSU_IDLE;
        req_ready_d = 1'b1;
        we_d        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= LSU_IDLE;
      req_ready_q  <= 1'b1;
      req_q        <= '0;
      addr_q       <= '0;
      n_q          <= 3'd1;
      k_q          <= 2'd0;
      asm_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_cause_q <= LSU_CAUSE_NONE;
      resp_data_q  <= '0;
      raddr_q      <= '0;
      waddr_q      <= '0;
      size_q       <= LOAD_WORD;
      wdata_q      <= '0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      n_q          <= n_d;
      k_q          <= k_d;
      asm_q        <= asm_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_cause_q <= resp_cause_d;
      resp_data_q  <= resp_data_d;
      raddr_q      <= raddr_d;
      waddr_q      <= waddr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
    end
  end

  // Write strobe is masked by the memory's own legality check on the presented address.
  assign mem_write_enable  = we_q & ~mem_illegal_write_address;
  assign req_ready         = req_ready_q;
  assign resp_valid        = resp_valid_q;
  assign resp_fault        = resp_fault_q;
  assign resp_cause        = resp_cause_q;
  assign resp_data         = resp_data_q;
  assign mem_read_address  = raddr_q;
  assign mem_write_address = waddr_q;
  assign mem_size_and_sign = size_q;
  assign mem_write_data    = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a byte-addressed ROM/RAM model (RAM 0x1000-0x1FFF).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_address, req_store_data;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_data;
  logic [1:0]  resp_cause;
  logic [31:0] mem_read_address, mem_read_data, mem_write_address, mem_write_data;
  logic        mem_illegal_read_address, mem_illegal_write_address, mem_write_enable;
  logic [2:0]  mem_size_and_sign;

  int checks = 0;
  int failures = 0;
  int wcnt = 0;

  logic [7:0] mem_b [8192];

  always #5 clk = ~clk;

  load_store_unit #(.SPLIT_MISALIGNED(1'b1), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_address(req_address), .req_store_data(req_store_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_fault(resp_fault), .resp_cause(resp_cause),
    .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
    .mem_illegal_read_address(mem_illegal_read_address),
    .mem_illegal_write_address(mem_illegal_write_address),
    .mem_size_and_sign(mem_size_and_sign), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable)
  );

  // Memory model: combinational extended read, clocked sized write.
  logic [31:0] rword;
  always_comb begin
    rword = {mem_b[13'(mem_read_address + 32'd3)], mem_b[13'(mem_read_address + 32'd2)],
             mem_b[13'(mem_read_address + 32'd1)], mem_b[13'(mem_read_address)]};
    case (mem_size_and_sign)
      3'b000:  mem_read_data = {{24{rword[7]}}, rword[7:0]};
      3'b001:  mem_read_data = {{16{rword[15]}}, rword[15:0]};
      3'b100:  mem_read_data = {24'b0, rword[7:0]};
      3'b101:  mem_read_data = {16'b0, rword[15:0]};
      default: mem_read_data = rword;
    endcase
    mem_illegal_read_address  = mem_read_address >= 32'h2000;
    mem_illegal_write_address = (mem_write_address < 32'h1000) || (mem_write_address >= 32'h2000);
  end

  always @(posedge clk) begin
    if (mem_write_enable) begin
      wcnt <= wcnt + 1;
      mem_b[13'(mem_write_address)] <= mem_write_data[7:0];
      if (mem_size_and_sign[1:0] != 2'b00)
        mem_b[13'(mem_write_address + 32'd1)] <= mem_write_data[15:8];
      if (mem_size_and_sign[1:0] == 2'b10) begin
        mem_b[13'(mem_write_address + 32'd2)] <= mem_write_data[23:16];
        mem_b[13'(mem_write_address + 32'd3)] <= mem_write_data[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request, wait for acceptance, then count cycles until resp_valid.
  task automatic start_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, output int lat);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_address = a; req_store_data = d;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic txn(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input int exp_lat, input logic [31:0] exp_data,
                     input logic exp_fault, input logic [1:0] exp_cause, input int exp_writes);
    int lat, w0;
    w0 = wcnt;
    start_req(st, f3, a, d, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, resp_data, exp_data);
    check({tag, "_fault"}, 32'(resp_fault), 32'(exp_fault));
    check({tag, "_cause"}, 32'(resp_cause), 32'(exp_cause));
    check({tag, "_writes"}, 32'(wcnt - w0), 32'(exp_writes));
    finish_resp();
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, w0;
    for (int i = 0; i < 8192; i++) mem_b[i] = 8'h00;
    reset_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_address = '0; req_store_data = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_fault", 32'(resp_fault), 32'd0);
    check("rst_resp_cause", 32'(resp_cause), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_raddr", mem_read_address, 32'd0);
    check("rst_waddr", mem_write_address, 32'd0);
    check("rst_wdata", mem_write_data, 32'd0);
    check("rst_size", 32'(mem_size_and_sign), 32'd2);
    check("rst_we", 32'(mem_write_enable), 32'd0);
    @(negedge clk); reset_n = 1'b1;

    txn("sw_aligned", 1'b1, 3'b010, 32'h1004, 32'hDEADBEEF, 2, 32'h0, 1'b0, 2'b00, 1);
    txn("lw_aligned", 1'b0, 3'b010, 32'h1004, 32'h0, 2, 32'hDEADBEEF, 1'b0, 2'b00, 0);
    txn("lh_split", 1'b0, 3'b001, 32'h1005, 32'h0, 3, 32'hFFFFADBE, 1'b0, 2'b00, 0);
    txn("lhu_split", 1'b0, 3'b101, 32'h1005, 32'h0, 3, 32'h0000ADBE, 1'b0, 2'b00, 0);
    txn("lb_aligned", 1'b0, 3'b000, 32'h1007, 32'h0, 2, 32'hFFFFFFDE, 1'b0, 2'b00, 0);
    txn("lh_aligned", 1'b0, 3'b001, 32'h1006, 32'h0, 2, 32'hFFFFDEAD, 1'b0, 2'b00, 0);

    txn("sw_split", 1'b1, 3'b010, 32'h1009, 32'h11223344, 5, 32'h0, 1'b0, 2'b00, 4);
    check("sw_split_b0", 32'(mem_b[13'h1009]), 32'h44);
    check("sw_split_b1", 32'(mem_b[13'h100A]), 32'h33);
    check("sw_split_b2", 32'(mem_b[13'h100B]), 32'h22);
    check("sw_split_b3", 32'(mem_b[13'h100C]), 32'h11);
    txn("lw_split", 1'b0, 3'b010, 32'h1009, 32'h0, 5, 32'h11223344, 1'b0, 2'b00, 0);

    txn("sh_split", 1'b1, 3'b001, 32'h1021, 32'h0000ABCD, 3, 32'h0, 1'b0, 2'b00, 2);
    check("sh_split_b0", 32'(mem_b[13'h1021]), 32'hCD);
    check("sh_split_b1", 32'(mem_b[13'h1022]), 32'hAB);

    txn("sb_rom", 1'b1, 3'b000, 32'h0000_0010, 32'h55, 2, 32'h0, 1'b1, 2'b10, 0);
    check("sb_rom_mem", 32'(mem_b[13'h0010]), 32'h00);
    // Split load crossing the end of RAM faults on its third byte.
    txn("lw_cross_end", 1'b0, 3'b010, 32'h1FFE, 32'h0, 4, 32'h0, 1'b1, 2'b10, 0);
    txn("st_illegal", 1'b1, 3'b011, 32'h1000, 32'h12345678, 1, 32'h0, 1'b1, 2'b11, 0);

    // Illegal load size with the consumer stalling for three cycles.
    w0 = wcnt;
    start_req(1'b0, 3'b011, 32'h1000, 32'h0, lat);
    check("ill_lat", 32'(lat), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("ill_hold_valid", 32'(resp_valid), 32'd1);
      check("ill_hold_req_ready", 32'(req_ready), 32'd0);
      check("ill_hold_cause", 32'(resp_cause), 32'd3);
      check("ill_hold_fault", 32'(resp_fault), 32'd1);
      check("ill_hold_data", resp_data, 32'd0);
      @(posedge clk); #1;
    end
    check("ill_writes", 32'(wcnt - w0), 32'd0);
    finish_resp();
    check("ill_ready_after", 32'(req_ready), 32'd1);

    // Reset during the second byte of a split store.
    w0 = wcnt;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
    req_address = 32'h1011; req_store_data = 32'hA1B2C3D4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstmid_req_ready_busy", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("rstmid_we_second", 32'(mem_write_enable), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rstmid_we_drop", 32'(mem_write_enable), 32'd0);
    check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
    check("rstmid_byte0", 32'(mem_b[13'h1011]), 32'hD4);
    check("rstmid_byte1", 32'(mem_b[13'h1012]), 32'h00);
    check("rstmid_writes", 32'(wcnt - w0), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rstmid_req_ready", 32'(req_ready), 32'd1);
    check("rstmid_byte1_after", 32'(mem_b[13'h1012]), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
